// File: rtl/bgr_pkg.sv
// Purpose: shared pixel types and width helpers for the background-removal path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bgr_pkg;

  // Pixel layout on the bus: {B[23:16], G[15:8], R[7:0]}.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Pure green, the usual replacement colour.
  localparam rgb_t BG_DEFAULT = '{b: 8'h00, g: 8'hFF, r: 8'h00};

  // Bits needed to index n items (at least 1).
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count from 0 to max_count inclusive.
  function automatic int unsigned count_width(input int unsigned max_count);
    return bits_for(max_count + 1);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Purpose: synchronous pixel FIFO with registered read data and synchronous flush.
// Latency: 1 clk from pop to rdata; occupancy visible the cycle after push/pop.
// Backpressure: none internally; caller must not push when full unless popping.
// Ports: clk/rst_n clock and async active-low reset; flush clears pointers;
//        push/wdata write side; pop/rdata read side; full/empty/level status.
module pixel_fifo
  import bgr_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           full,
  output logic                           empty,
  output logic [count_width(DEPTH)-1:0]  level
);

  localparam int AW    = bits_for(DEPTH);
  localparam int LVL_W = count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]           wr_q, wr_d;
  logic [AW:0]           rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop) begin
        rd_d    = rd_q + 1'b1;
        rdata_d = mem[rd_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage needs no reset; a full-FIFO push+pop reads the old entry at this
  // slot before the new write lands.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = LVL_W'(wr_q - rd_q);
  assign rdata = rdata_q;

endmodule

// File: rtl/bg_pixel_composer.sv
// Purpose: pair each mask bit with the oldest buffered pixel; emit pixel or background colour.
// Latency: exactly 1 clk from i_MASK_VALID to o_VALID.
// Backpressure: none; pixels arriving on a full FIFO are dropped (o_OVF), masks on empty dropped (o_UNF).
// Ports: i_VALID/i_DATA pixel in; i_MASK_VALID/i_MASK mask in; i_BG_COLOR replacement;
//        i_CLR sync flush; o_VALID/o_DATA/o_EOL pixel out; o_FG_COUNT last-line fg count;
//        o_LEVEL FIFO occupancy; o_OVF/o_UNF sticky error flags.
module bg_pixel_composer
  import bgr_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_WIDTH = 640
) (
  input  logic                                i_CLK,
  input  logic                                i_RSTn,
  input  logic                                i_VALID,
  input  logic [DATA_WIDTH-1:0]               i_DATA,
  input  logic                                i_MASK_VALID,
  input  logic                                i_MASK,
  input  logic [DATA_WIDTH-1:0]               i_BG_COLOR,
  input  logic                                i_CLR,
  output logic                                o_VALID,
  output logic [DATA_WIDTH-1:0]               o_DATA,
  output logic                                o_EOL,
  output logic [count_width(LINE_WIDTH)-1:0]  o_FG_COUNT,
  output logic [count_width(FIFO_DEPTH)-1:0]  o_LEVEL,
  output logic                                o_OVF,
  output logic                                o_UNF
);

  localparam int COL_W = bits_for(LINE_WIDTH);
  localparam int FG_W  = count_width(LINE_WIDTH);
  localparam int LVL_W = count_width(FIFO_DEPTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [LVL_W-1:0]      fifo_level;
  logic                  push_en, pop_en;

  logic                  valid_q, valid_d;
  logic                  eol_q, eol_d;
  logic                  mask_q, mask_d;
  logic [DATA_WIDTH-1:0] bg_q, bg_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [FG_W-1:0]       acc_q, acc_d;
  logic [FG_W-1:0]       fg_q, fg_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // Clear wins over everything. A pop frees a slot in the same cycle, so a
  // full FIFO can still accept a pixel alongside a mask. No empty bypass.
  assign pop_en  = i_MASK_VALID & ~fifo_empty & ~i_CLR;
  assign push_en = i_VALID & (~fifo_full | pop_en) & ~i_CLR;

  pixel_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RSTn),
    .flush (i_CLR),
    .push  (push_en),
    .wdata (i_DATA),
    .pop   (pop_en),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    valid_d = 1'b0;
    eol_d   = 1'b0;
    mask_d  = mask_q;
    bg_d    = bg_q;
    col_d   = col_q;
    acc_d   = acc_q;
    fg_d    = fg_q;
    ovf_d   = ovf_q | (i_VALID & fifo_full & ~pop_en);
    unf_d   = unf_q | (i_MASK_VALID & fifo_empty);
    if (i_CLR) begin
      // Foreground count of the last completed line survives a flush.
      ovf_d = 1'b0;
      unf_d = 1'b0;
      col_d = '0;
      acc_d = '0;
    end else if (pop_en) begin
      valid_d = 1'b1;
      mask_d  = i_MASK;
      bg_d    = i_BG_COLOR;
      if (col_q == LAST_COL) begin
        eol_d = 1'b1;
        col_d = '0;
        fg_d  = acc_q + FG_W'(i_MASK);
        acc_d = '0;
      end else begin
        col_d = col_q + COL_W'(1);
        acc_d = acc_q + FG_W'(i_MASK);
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      mask_q  <= 1'b0;
      bg_q    <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      fg_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      eol_q   <= eol_d;
      mask_q  <= mask_d;
      bg_q    <= bg_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      fg_q    <= fg_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // FIFO read data and the captured mask/colour all settle in the pop cycle,
  // so the select happens on registered values only.
  assign o_DATA     = mask_q ? fifo_rdata : bg_q;
  assign o_VALID    = valid_q;
  assign o_EOL      = eol_q;
  assign o_FG_COUNT = fg_q;
  assign o_LEVEL    = fifo_level;
  assign o_OVF      = ovf_q;
  assign o_UNF      = unf_q;

endmodule

// File: tb/tb_bg_pixel_composer.sv
// Purpose: self-checking bench for bg_pixel_composer against a queue-based reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_bg_pixel_composer;
  import bgr_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int LW    = 8;

  logic          i_CLK = 1'b0;
  logic          i_RSTn = 1'b0;
  logic          i_VALID = 1'b0;
  logic [DW-1:0] i_DATA = '0;
  logic          i_MASK_VALID = 1'b0;
  logic          i_MASK = 1'b0;
  logic [DW-1:0] i_BG_COLOR = '0;
  logic          i_CLR = 1'b0;
  logic          o_VALID;
  logic [DW-1:0] o_DATA;
  logic          o_EOL;
  logic [3:0]    o_FG_COUNT;
  logic [4:0]    o_LEVEL;
  logic          o_OVF;
  logic          o_UNF;

  bg_pixel_composer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .LINE_WIDTH (LW)
  ) dut (
    .i_CLK        (i_CLK),
    .i_RSTn       (i_RSTn),
    .i_VALID      (i_VALID),
    .i_DATA       (i_DATA),
    .i_MASK_VALID (i_MASK_VALID),
    .i_MASK       (i_MASK),
    .i_BG_COLOR   (i_BG_COLOR),
    .i_CLR        (i_CLR),
    .o_VALID      (o_VALID),
    .o_DATA       (o_DATA),
    .o_EOL        (o_EOL),
    .o_FG_COUNT   (o_FG_COUNT),
    .o_LEVEL      (o_LEVEL),
    .o_OVF        (o_OVF),
    .o_UNF        (o_UNF)
  );

  always #5 i_CLK = ~i_CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: pixel queue, sticky flags, line position, fg counts.
  logic [DW-1:0] ref_q[$];
  bit            ref_ovf, ref_unf;
  int            ref_col, ref_acc, ref_fg;
  bit            exp_valid, exp_eol;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] bg_green;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    ref_ovf = 0; ref_unf = 0;
    ref_col = 0; ref_acc = 0; ref_fg = 0;
    exp_valid = 0; exp_eol = 0; exp_data = '0;
  endtask

  // One clock of behaviour: pop (if any) happens before this cycle's push.
  task automatic model_cycle(input bit v, input logic [DW-1:0] d, input bit mv,
                             input bit m, input logic [DW-1:0] bg, input bit clr);
    logic [DW-1:0] px;
    exp_valid = 0;
    exp_eol   = 0;
    if (clr) begin
      ref_q.delete();
      ref_ovf = 0; ref_unf = 0; ref_col = 0; ref_acc = 0;
    end else begin
      if (mv && ref_q.size() > 0) begin
        px        = ref_q.pop_front();
        exp_valid = 1;
        exp_data  = m ? px : bg;
        ref_acc  += int'(m);
        ref_col++;
        if (ref_col == LW) begin
          exp_eol = 1;
          ref_fg  = ref_acc;
          ref_acc = 0;
          ref_col = 0;
        end
      end else if (mv) begin
        ref_unf = 1;
      end
      if (v) begin
        if (ref_q.size() < DEPTH) ref_q.push_back(d);
        else ref_ovf = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(o_VALID), 32'(exp_valid));
    if (exp_valid) chk({tag, "_data"}, 32'(o_DATA), 32'(exp_data));
    chk({tag, "_eol"},   32'(o_EOL),      32'(exp_eol));
    chk({tag, "_fg"},    32'(o_FG_COUNT), 32'(ref_fg));
    chk({tag, "_level"}, 32'(o_LEVEL),    32'(ref_q.size()));
    chk({tag, "_ovf"},   32'(o_OVF),      32'(ref_ovf));
    chk({tag, "_unf"},   32'(o_UNF),      32'(ref_unf));
  endtask

  task automatic step(input string tag, input bit v, input logic [DW-1:0] d,
                      input bit mv, input bit m, input logic [DW-1:0] bg, input bit clr);
    i_VALID = v; i_DATA = d; i_MASK_VALID = mv; i_MASK = m; i_BG_COLOR = bg; i_CLR = clr;
    @(posedge i_CLK);
    model_cycle(v, d, mv, m, bg, clr);
    #1;
    check_all(tag);
    @(negedge i_CLK);
  endtask

  function automatic logic [DW-1:0] rnd_px();
    return DW'($urandom());
  endfunction

  logic [DW-1:0] px[LW];
  bit            line_mask[LW];

  initial begin
    bg_green = BG_DEFAULT;
    model_reset();

    // Reset state
    repeat (2) @(negedge i_CLK);
    #1;
    chk("rst_data", 32'(o_DATA), 32'h0);
    check_all("rst");
    i_RSTn = 1'b1;
    @(negedge i_CLK);

    // 1: four pixels, an idle cycle, then masks 1,0,1,1 on green
    for (int i = 0; i < 4; i++) begin
      px[i] = rnd_px();
      step("t1_push", 1, px[i], 0, 0, bg_green, 0);
    end
    step("t1_idle", 0, '0, 0, 0, bg_green, 0);
    step("t1_m0", 0, '0, 1, 1, bg_green, 0);
    chk("t1_px0", 32'(o_DATA), 32'(px[0]));
    step("t1_m1", 0, '0, 1, 0, bg_green, 0);
    chk("t1_bg", 32'(o_DATA), 32'h00FF00);
    step("t1_m2", 0, '0, 1, 1, bg_green, 0);
    chk("t1_px2", 32'(o_DATA), 32'(px[2]));
    step("t1_m3", 0, '0, 1, 1, bg_green, 0);
    chk("t1_px3", 32'(o_DATA), 32'(px[3]));
    step("t1_clr", 0, '0, 0, 0, bg_green, 1);

    // 2: seventeen pixels overflow a 16-deep FIFO, then drain in order
    for (int i = 0; i < 17; i++) step("t2_push", 1, rnd_px(), 0, 0, bg_green, 0);
    chk("t2_level16", 32'(o_LEVEL), 32'd16);
    chk("t2_ovf", 32'(o_OVF), 32'd1);
    for (int i = 0; i < 16; i++) step("t2_pop", 0, '0, 1, 1, rnd_px(), 0);
    step("t2_clr", 0, '0, 0, 0, bg_green, 1);

    // 5: full FIFO, push and pop in one cycle
    for (int i = 0; i < 16; i++) step("t5_fill", 1, rnd_px(), 0, 0, bg_green, 0);
    step("t5_pushpop", 1, rnd_px(), 1, 1, bg_green, 0);
    chk("t5_level", 32'(o_LEVEL), 32'd16);
    chk("t5_noovf", 32'(o_OVF), 32'd0);
    for (int i = 0; i < 16; i++) step("t5_drain", 0, '0, 1, i[0], rnd_px(), 0);
    step("t5_clr", 0, '0, 0, 0, bg_green, 1);

    // 3: mask on empty FIFO in the same cycle as the first push
    step("t3_underflow", 1, rnd_px(), 1, 1, bg_green, 0);
    chk("t3_unf", 32'(o_UNF), 32'd1);
    chk("t3_level", 32'(o_LEVEL), 32'd1);
    step("t3_pop", 0, '0, 1, 1, bg_green, 0);
    step("t3_clr", 0, '0, 0, 0, bg_green, 1);

    // 4: one line of 8 with masks 1,1,0,1,0,0,1,1, then a random line
    line_mask = '{1, 1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < LW; i++) step("t4_push", 1, rnd_px(), 0, 0, bg_green, 0);
    for (int i = 0; i < LW; i++) step("t4_mask", 0, '0, 1, line_mask[i], bg_green, 0);
    chk("t4_eol", 32'(o_EOL), 32'd1);
    chk("t4_fg5", 32'(o_FG_COUNT), 32'd5);
    for (int i = 0; i < LW; i++) step("t4_line2", 1, rnd_px(), 1, 1'($urandom()), rnd_px(), 0);
    step("t4_tail", 0, '0, 1, 1, bg_green, 0);

    // 6: level 5 with overflow set, then clear
    step("t6_clr0", 0, '0, 0, 0, bg_green, 1);
    for (int i = 0; i < 17; i++) step("t6_fill", 1, rnd_px(), 0, 0, bg_green, 0);
    for (int i = 0; i < 11; i++) step("t6_pop", 0, '0, 1, 1, bg_green, 0);
    chk("t6_level5", 32'(o_LEVEL), 32'd5);
    step("t6_clr", 1, rnd_px(), 1, 1, bg_green, 1);
    chk("t6_level0", 32'(o_LEVEL), 32'd0);
    chk("t6_ovf0", 32'(o_OVF), 32'd0);
    chk("t6_novalid", 32'(o_VALID), 32'd0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step("rnd", ($urandom_range(0, 9) < 6), rnd_px(), ($urandom_range(0, 9) < 5),
           1'($urandom()), rnd_px(), ($urandom_range(0, 49) == 0));

    // Async reset between clock edges
    i_VALID = 1; i_MASK_VALID = 1; i_MASK = 1;
    #2;
    i_RSTn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(o_VALID), 32'd0);
    chk("arst_data",  32'(o_DATA),  32'd0);
    chk("arst_eol",   32'(o_EOL),   32'd0);
    chk("arst_fg",    32'(o_FG_COUNT), 32'd0);
    chk("arst_level", 32'(o_LEVEL), 32'd0);
    chk("arst_ovf",   32'(o_OVF),   32'd0);
    chk("arst_unf",   32'(o_UNF),   32'd0);
    i_VALID = 0; i_MASK_VALID = 0; i_MASK = 0;
    @(negedge i_CLK);
    i_RSTn = 1'b1;
    step("post_rst", 1, rnd_px(), 0, 0, bg_green, 0);
    step("post_rst_pop", 0, '0, 1, 0, bg_green, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
